// File: rtl/irq_gen.sv
// irq_gen: per-line synchronize/debounce, latch rising edges as pending, issue fixed-width spaced pulses.
// Optional macro IRQ_GEN_COUNT_EN adds a 32-bit count of issued pulses on irq_count (tied to 0 otherwise).

module irq_gen_line #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PULSE_CYCLES    = 1,
  parameter int GAP_CYCLES      = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic btn_i,
  input  logic mask_i,
  input  logic halt_i,
  output logic irq_o,
  output logic pend_o
`ifdef IRQ_GEN_COUNT_EN
  , output logic start_o
`endif
);
  localparam int CW   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int TMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, PULSE = 2'd1, GAP = 2'd2} state_e;

  logic          s1_q, s_q;
  logic          db_q, db_d, dbp_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic [TW-1:0] tmr_q, tmr_d;
  state_e        state_q, state_d;
  logic          rise, issue, start;

  always_ff @(posedge clk) begin
    if (clr) begin
      s1_q    <= 1'b0;
      s_q     <= 1'b0;
      db_q    <= 1'b0;
      dbp_q   <= 1'b0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      tmr_q   <= '0;
      state_q <= IDLE;
    end else begin
      s1_q    <= btn_i;
      s_q     <= s1_q;
      db_q    <= db_d;
      dbp_q   <= db_q;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      tmr_q   <= tmr_d;
      state_q <= state_d;
    end
  end

  // Any sample that agrees with the accepted level restarts the stability count.
  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    if (s_q == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      db_d  = s_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign rise  = db_q & ~dbp_q;
  assign issue = pend_q & ~mask_i & ~halt_i;

  // The last GAP cycle may hand straight over to a new pulse, so back-to-back
  // requests are separated by exactly GAP_CYCLES low cycles.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (issue) begin
          state_d = PULSE;
          tmr_d   = TW'(PULSE_CYCLES - 1);
          start   = 1'b1;
        end
      end
      PULSE: begin
        if (tmr_q == '0) begin
          state_d = GAP;
          tmr_d   = TW'(GAP_CYCLES - 1);
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      GAP: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - TW'(1);
        end else if (issue) begin
          state_d = PULSE;
          tmr_d   = TW'(PULSE_CYCLES - 1);
          start   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        tmr_d   = '0;
      end
    endcase
  end

  // A new rise beats the consume in the same edge.
  assign pend_d = rise | (pend_q & ~start);

  always_comb begin
    irq_o  = (state_q == PULSE);
    pend_o = pend_q;
  end

`ifdef IRQ_GEN_COUNT_EN
  assign start_o = start;
`endif
endmodule

module irq_gen #(
  parameter int NUM_LINES       = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PULSE_CYCLES    = 1,
  parameter int GAP_CYCLES      = 4
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [NUM_LINES-1:0] btn,
  input  logic [NUM_LINES-1:0] mask,
  input  logic                 halt,
  output logic [NUM_LINES-1:0] hardware_interrupt,
  output logic [NUM_LINES-1:0] pending,
  output logic [31:0]          irq_count
);
`ifdef IRQ_GEN_COUNT_EN
  logic [NUM_LINES-1:0] start;
`endif

  for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
    irq_gen_line #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .PULSE_CYCLES   (PULSE_CYCLES),
      .GAP_CYCLES     (GAP_CYCLES)
    ) u_line (
      .clk    (clk),
      .clr    (clr),
      .btn_i  (btn[i]),
      .mask_i (mask[i]),
      .halt_i (halt),
      .irq_o  (hardware_interrupt[i]),
      .pend_o (pending[i])
`ifdef IRQ_GEN_COUNT_EN
      , .start_o(start[i])
`endif
    );
  end

`ifdef IRQ_GEN_COUNT_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NUM_LINES; i++) cnt_d = cnt_d + 32'(start[i]);
  end

  always_ff @(posedge clk) begin
    if (clr) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign irq_count = cnt_q;
`else
  assign irq_count = 32'h0;
`endif
endmodule

// File: tb/tb_irq_gen.sv
// Directed + randomized bench for irq_gen against an edge-indexed behavioural model.
module tb_irq_gen;
  localparam int N = 8, D = 4, P = 2, G = 3;

  logic         clk = 1'b0;
  logic         clr, halt;
  logic [N-1:0] btn, mask, hw, pend;
  logic [31:0]  cnt;

  irq_gen #(.NUM_LINES(N), .DEBOUNCE_CYCLES(D), .PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
    .clk(clk), .clr(clr), .btn(btn), .mask(mask), .halt(halt),
    .hardware_interrupt(hw), .pending(pend), .irq_count(cnt)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // Model: synchronizer samples, accepted level, mismatch streak, and the edge
  // index at which each line's most recent pulse began.
  bit          m_s1[N], m_s[N], m_db[N], m_dbp[N], m_pend[N];
  int          m_run[N], m_ps[N];
  int          e = 0;
  bit   [31:0] m_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h edge=%0d", tag, obs, exp, e);
    end
  endtask

  task automatic model_edge();
    bit rise, iss;
    int started;
    started = 0;
    e++;
    if (clr) begin
      for (int i = 0; i < N; i++) begin
        m_s1[i] = 0; m_s[i] = 0; m_db[i] = 0; m_dbp[i] = 0; m_pend[i] = 0;
        m_run[i] = 0; m_ps[i] = -1000;
      end
      m_cnt = 0;
      return;
    end
    for (int i = 0; i < N; i++) begin
      rise = m_db[i] && !m_dbp[i];
      // A line may start once its previous pulse plus G low cycles are over.
      iss  = m_pend[i] && !mask[i] && !halt && (e >= m_ps[i] + P + G);
      if (iss) begin
        m_ps[i] = e;
        started++;
      end
      m_pend[i] = rise || (m_pend[i] && !iss);
      m_dbp[i]  = m_db[i];
      if (m_s[i] != m_db[i]) begin
        m_run[i]++;
        if (m_run[i] == D) begin
          m_db[i]  = m_s[i];
          m_run[i] = 0;
        end
      end else m_run[i] = 0;
      m_s[i]  = m_s1[i];
      m_s1[i] = btn[i];
    end
    m_cnt = m_cnt + 32'(started);
  endtask

  function automatic logic [N-1:0] exp_hw();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = (e >= m_ps[i]) && (e < m_ps[i] + P);
    return r;
  endfunction

  function automatic logic [N-1:0] exp_pend();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = m_pend[i];
    return r;
  endfunction

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("hw", 32'(hw), 32'(exp_hw()));
      check("pending", 32'(pend), 32'(exp_pend()));
`ifdef IRQ_GEN_COUNT_EN
      check("irq_count", cnt, m_cnt);
`else
      check("irq_count_off", cnt, 32'h0);
`endif
    end
  endtask

  initial begin
    clr = 1'b1; halt = 1'b0; btn = '0; mask = '0;
    @(negedge clk);
    tick(2);
    clr = 1'b0;
    check("rst_hw", 32'(hw), 32'h0);
    check("rst_pend", 32'(pend), 32'h0);
    check("rst_cnt", cnt, 32'h0);
    tick(3);

    // Latency: pending 6 edges and pulse 7..8 edges after first sampling edge.
    btn[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 6)  check("t1_pend_early", 32'(pend[0]), 32'h0);
      if (k == 7)  check("t1_pend_set", 32'(pend[0]), 32'h1);
      if (k == 7)  check("t1_hw_low", 32'(hw[0]), 32'h0);
      if (k == 8)  check("t1_hw_hi0", 32'(hw[0]), 32'h1);
      if (k == 8)  check("t1_pend_clr", 32'(pend[0]), 32'h0);
      if (k == 9)  check("t1_hw_hi1", 32'(hw[0]), 32'h1);
      if (k == 10) check("t1_hw_end", 32'(hw[0]), 32'h0);
    end
    btn[0] = 1'b0;
    tick(8);

    // Bounce on line 1, then stable high.
    for (int r = 0; r < 3; r++) begin
      btn[1] = 1'b1; tick(2);
      btn[1] = 1'b0; tick(1);
    end
    btn[1] = 1'b1;
    tick(12);

    // Masked line keeps its request pending until unmasked.
    mask[2] = 1'b1; btn[2] = 1'b1;
    tick(12);
    check("t3_mask_pend", 32'(pend[2]), 32'h1);
    check("t3_mask_hw", 32'(hw[2]), 32'h0);
    mask[2] = 1'b0;
    tick(6);
    halt = 1'b1; btn[4] = 1'b1;
    tick(12);
    check("t3_halt_pend", 32'(pend[4]), 32'h1);
    halt = 1'b0;
    tick(6);

    // Second rise during GAP on line 3; then several rises while masked.
    btn[3] = 1'b1; tick(8);
    btn[3] = 1'b0; tick(5);
    btn[3] = 1'b1; tick(15);
    mask[3] = 1'b1;
    for (int r = 0; r < 3; r++) begin
      btn[3] = 1'b0; tick(6);
      btn[3] = 1'b1; tick(6);
    end
    mask[3] = 1'b0;
    tick(12);

    // Reset mid-pulse on lines 0 and 5 with line 6 pending.
    btn = '0; tick(10);
    btn[0] = 1'b1; btn[5] = 1'b1; tick(2);
    btn[6] = 1'b1; mask[6] = 1'b1; tick(6);
    clr = 1'b1; tick(1);
    clr = 1'b0;
    check("t5_hw", 32'(hw), 32'h0);
    check("t5_pend", 32'(pend), 32'h0);
    check("t5_cnt", cnt, 32'h0);
    mask = '0;
    tick(14);

    // All lines together.
    btn = '0; tick(12);
    btn = '1;
    tick(8);
    check("t6_all_hw", 32'(hw), 32'hFF);
    tick(1);
    check("t6_all_hw2", 32'(hw), 32'hFF);
    tick(6);

    // Randomized: per-line toggles with random hold, occasional mask/halt/clr.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(5) == 0) btn[i] = ~btn[i];
      if ($urandom_range(19) == 0) mask = N'($urandom);
      if ($urandom_range(19) == 0) halt = ~halt;
      clr = ($urandom_range(199) == 0);
      tick();
    end
    clr = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
